// File: rtl/execute_pipelined.sv
// LEGv8 execute stage: single-cycle ALU plus iterative multiplier, feeding an
// EX/MEM register with a valid/ready handshake toward the memory stage.
module execute_pipelined #(
  parameter int unsigned N        = 64,
  parameter int unsigned MUL_STEP = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   AluSrc,
  input  logic [3:0]   AluControl,
  input  logic [N-1:0] PC_E,
  input  logic [N-1:0] signImm_E,
  input  logic [N-1:0] readData1_E,
  input  logic [N-1:0] readData2_E,
  input  logic [N-1:0] readData3_E,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] PCBranch_M,
  output logic [N-1:0] aluResult_M,
  output logic [N-1:0] writeData_M,
  output logic         zero_M,
  output logic         busy
);

  localparam int unsigned STEPS = N / MUL_STEP;
  localparam int unsigned CW    = $clog2(STEPS + 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1000;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t          r_state;
  logic            r_out_valid;
  logic [N-1:0]    r_pcb;
  logic [N-1:0]    r_res;
  logic [N-1:0]    r_wd;
  logic            r_zero;
  logic [N-1:0]    r_ma;
  logic [N-1:0]    r_mb;
  logic [N-1:0]    r_acc;
  logic [N-1:0]    r_mul_pcb;
  logic [N-1:0]    r_mul_wd;
  logic [CW-1:0]   r_cnt;

  logic [N-1:0]    w_b;
  logic [N-1:0]    w_alu;
  logic [N-1:0]    w_pcb;
  logic [N-1:0]    w_partial;
  logic [N-1:0]    w_acc_next;
  logic            w_accept;

  always_comb begin
    w_b = readData3_E;
    case (AluSrc)
      2'b00:   w_b = readData2_E;
      2'b01:   w_b = signImm_E;
      default: w_b = readData3_E;
    endcase
  end

  // MUL is handled by the iterative datapath; unlisted codes yield zero.
  always_comb begin
    w_alu = '0;
    case (AluControl)
      OP_AND:  w_alu = readData1_E & w_b;
      OP_OR:   w_alu = readData1_E | w_b;
      OP_ADD:  w_alu = readData1_E + w_b;
      OP_SUB:  w_alu = readData1_E - w_b;
      OP_PASS: w_alu = w_b;
      OP_NOR:  w_alu = ~(readData1_E | w_b);
      default: w_alu = '0;
    endcase
  end

  assign w_pcb = PC_E + (signImm_E << 2);

  // Partial products for the next MUL_STEP multiplier bits; r_ma pre-shifted.
  always_comb begin
    w_partial = '0;
    for (int j = 0; j < int'(MUL_STEP); j++) begin
      if (r_mb[j]) w_partial = w_partial + (r_ma << j);
    end
  end

  assign w_acc_next = r_acc + w_partial;
  assign in_ready   = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_pcb       <= '0;
      r_res       <= '0;
      r_wd        <= '0;
      r_zero      <= 1'b0;
      r_ma        <= '0;
      r_mb        <= '0;
      r_acc       <= '0;
      r_mul_pcb   <= '0;
      r_mul_wd    <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (AluControl == OP_MUL) begin
              r_ma        <= readData1_E;
              r_mb        <= w_b;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_mul_pcb   <= w_pcb;
              r_mul_wd    <= readData2_E;
              r_out_valid <= 1'b0;
              r_state     <= S_MUL;
            end else begin
              r_res       <= w_alu;
              r_zero      <= (w_alu == '0);
              r_pcb       <= w_pcb;
              r_wd        <= readData2_E;
              r_out_valid <= 1'b1;
            end
          end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        S_MUL: begin
          r_acc <= w_acc_next;
          r_ma  <= r_ma << MUL_STEP;
          r_mb  <= r_mb >> MUL_STEP;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(STEPS - 1)) begin
            r_res       <= w_acc_next;
            r_zero      <= (w_acc_next == '0);
            r_pcb       <= r_mul_pcb;
            r_wd        <= r_mul_wd;
            r_out_valid <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid   = r_out_valid;
  assign PCBranch_M  = r_pcb;
  assign aluResult_M = r_res;
  assign writeData_M = r_wd;
  assign zero_M      = r_zero;
  assign busy        = (r_state == S_MUL);

endmodule

// File: tb/tb_execute_pipelined.sv
// Self-checking bench for execute_pipelined: directed vectors, multi-cycle
// corner sequences and random traffic against a transaction-level model.
module tb_execute_pipelined;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_valid4, in_ready4;
  logic [1:0]  AluSrc;
  logic [3:0]  AluControl;
  logic [63:0] PC_E, signImm_E, readData1_E, readData2_E, readData3_E;
  logic        out_valid, out_ready, out_valid4, out_ready4;
  logic [63:0] PCBranch_M, aluResult_M, writeData_M;
  logic [63:0] PCBranch_M4, aluResult_M4, writeData_M4;
  logic        zero_M, zero_M4, busy, busy4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  execute_pipelined #(.N(64), .MUL_STEP(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .AluSrc(AluSrc), .AluControl(AluControl), .PC_E(PC_E), .signImm_E(signImm_E),
    .readData1_E(readData1_E), .readData2_E(readData2_E), .readData3_E(readData3_E),
    .out_valid(out_valid), .out_ready(out_ready), .PCBranch_M(PCBranch_M),
    .aluResult_M(aluResult_M), .writeData_M(writeData_M), .zero_M(zero_M), .busy(busy)
  );

  execute_pipelined #(.N(64), .MUL_STEP(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .AluSrc(AluSrc), .AluControl(AluControl), .PC_E(PC_E), .signImm_E(signImm_E),
    .readData1_E(readData1_E), .readData2_E(readData2_E), .readData3_E(readData3_E),
    .out_valid(out_valid4), .out_ready(out_ready4), .PCBranch_M(PCBranch_M4),
    .aluResult_M(aluResult_M4), .writeData_M(writeData_M4), .zero_M(zero_M4), .busy(busy4)
  );

  typedef struct {
    logic [1:0]  src;
    logic [3:0]  ctrl;
    logic [63:0] pc, imm, a, r2, r3, res, pcb;
    logic        zero;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_alu(input logic [3:0] c, input logic [63:0] a,
                                          input logic [63:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return b;
      4'b1100: return ~(a | b);
      4'b1000: return a * b;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] ref_b(input logic [1:0] s, input logic [63:0] r2,
                                        input logic [63:0] imm, input logic [63:0] r3);
    if (s == 2'b00) return r2;
    if (s == 2'b01) return imm;
    return r3;
  endfunction

  task automatic drive(input logic [1:0] s, input logic [3:0] c, input logic [63:0] pc,
                       input logic [63:0] imm, input logic [63:0] a, input logic [63:0] r2,
                       input logic [63:0] r3);
    AluSrc = s; AluControl = c; PC_E = pc; signImm_E = imm;
    readData1_E = a; readData2_E = r2; readData3_E = r3;
  endtask

  // Transaction-level model state for the random phase.
  logic        m_ov;
  int          m_left;
  logic [63:0] m_res, m_pcb, m_wd, p_res, p_pcb, p_wd;
  logic        acc, xfer;
  logic [63:0] c_res, c_pcb;
  logic [3:0]  codes [8];

  initial begin
    int lat1, lat4;
    logic [63:0] r1, r4;
    bit found;

    vecs.push_back('{2'b01, 4'b0010, 64'h100, 64'd3, 64'd5, 64'd0, 64'd0, 64'd8, 64'h10C, 1'b0});
    vecs.push_back('{2'b00, 4'b0110, 64'h200, 64'd0, 64'h1234, 64'h1234, 64'd0, 64'd0, 64'h200, 1'b1});
    vecs.push_back('{2'b00, 4'b0001, 64'h0, 64'd0, 64'hF0, 64'h0F, 64'd0, 64'hFF, 64'h0, 1'b0});
    vecs.push_back('{2'b00, 4'b0000, 64'h0, 64'd0, 64'hF0F0, 64'hFF00, 64'd0, 64'hF000, 64'h0, 1'b0});
    vecs.push_back('{2'b00, 4'b1100, 64'h0, 64'd0, 64'd0, 64'd0, 64'd0, '1, 64'h0, 1'b0});
    vecs.push_back('{2'b10, 4'b0111, 64'h0, 64'd0, 64'd1, 64'd2, 64'hABCD, 64'hABCD, 64'h0, 1'b0});
    vecs.push_back('{2'b11, 4'b0111, 64'h10, 64'd5, 64'd1, 64'd9, 64'd0, 64'd0, 64'h24, 1'b1});
    vecs.push_back('{2'b00, 4'b1111, 64'h40, 64'd1, 64'hFF, 64'hFF, 64'd0, 64'd0, 64'h44, 1'b1});
    vecs.push_back('{2'b00, 4'b0010, 64'h0, 64'd0, '1, 64'd1, 64'd0, 64'd0, 64'h0, 1'b1});
    vecs.push_back('{2'b00, 4'b0110, 64'h0, 64'd0, 64'd3, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 1'b0});
    vecs.push_back('{2'b00, 4'b1000, 64'h8, '1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0,
                     64'hFFFF_FFFF_FFFF_FFEB, 64'h4, 1'b0});
    vecs.push_back('{2'b01, 4'b1000, 64'h0, 64'h1_0000_0000, 64'h1_0000_0000, 64'd6, 64'd0,
                     64'd0, 64'h4_0000_0000, 1'b1});
    vecs.push_back('{2'b01, 4'b0010, 64'hFFFF_FFFF_FFFF_FFFC, 64'd2, 64'd0, 64'd0, 64'd0,
                     64'd2, 64'h4, 1'b0});

    reset = 1'b1; in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b1; out_ready4 = 1'b1;
    drive(2'b00, 4'b0000, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_alu", aluResult_M, 64'd0);
    chk("reset_pcb", PCBranch_M, 64'd0);
    chk("reset_zero", 64'(zero_M), 64'd0);

    // Directed vector table
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive(vecs[i].src, vecs[i].ctrl, vecs[i].pc, vecs[i].imm, vecs[i].a, vecs[i].r2, vecs[i].r3);
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
        @(negedge clk);
        if (out_valid) found = 1'b1;
      end
      chk($sformatf("vec%0d_valid", i), 64'(found), 64'd1);
      chk($sformatf("vec%0d_res", i), aluResult_M, vecs[i].res);
      chk($sformatf("vec%0d_zero", i), 64'(zero_M), 64'(vecs[i].zero));
      chk($sformatf("vec%0d_pcb", i), PCBranch_M, vecs[i].pcb);
      chk($sformatf("vec%0d_wd", i), writeData_M, vecs[i].r2);
    end

    // Back-to-back single-cycle ops
    @(posedge clk); #1;
    drive(2'b00, 4'b0110, 64'h0, 64'd0, 64'h1234, 64'h1234, 64'd0);
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    drive(2'b00, 4'b0010, 64'h0, 64'd0, 64'd2, 64'd3, 64'd0);
    @(negedge clk);
    chk("b2b_first_res", aluResult_M, 64'd0);
    chk("b2b_first_zero", 64'(zero_M), 64'd1);
    chk("b2b_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_second_valid", 64'(out_valid), 64'd1);
    chk("b2b_second_res", aluResult_M, 64'd5);

    // Backpressure with a pending ADD
    @(posedge clk); #1;
    drive(2'b00, 4'b0001, 64'h0, 64'd0, 64'hF0, 64'h0F, 64'd0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(2'b00, 4'b0010, 64'h0, 64'd0, 64'd1, 64'd1, 64'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_res", aluResult_M, 64'hFF);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1; #1;
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", 64'(out_valid), 64'd1);
    chk("bp_next_res", aluResult_M, 64'd2);

    // MUL latency for both step sizes
    @(posedge clk); #1;
    drive(2'b00, 4'b1000, 64'h0, 64'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0);
    in_valid = 1'b1; in_valid4 = 1'b1; out_ready = 1'b1; out_ready4 = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_valid4 = 1'b0;
    lat1 = 0; lat4 = 0; r1 = '0; r4 = '0;
    for (int k = 1; k <= 80; k++) begin
      if (lat1 == 0 && (busy !== 1'b1 || in_ready !== 1'b0)) begin
        chk("mul_busy_stall", {busy, in_ready}, 64'b10);
      end
      @(posedge clk); #1;
      if (lat1 == 0 && out_valid) begin lat1 = k; r1 = aluResult_M; end
      if (lat4 == 0 && out_valid4) begin lat4 = k; r4 = aluResult_M4; end
    end
    chk("mul_latency_step1", 64'(lat1), 64'd64);
    chk("mul_result_step1", r1, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("mul_latency_step4", 64'(lat4), 64'd16);
    chk("mul_result_step4", r4, 64'hFFFF_FFFF_FFFF_FFEB);

    // Reset in the middle of a multiply
    drive(2'b00, 4'b1000, 64'h0, 64'd0, 64'd9, 64'd9, 64'd0);
    in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    chk("rst_mid_outputs", aluResult_M | PCBranch_M | writeData_M | 64'(zero_M), 64'd0);

    // Random traffic against the transaction-level model
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1000, 4'b1111};
    m_ov = 1'b0; m_left = 0; m_res = '0; m_pcb = '0; m_wd = '0;
    p_res = '0; p_pcb = '0; p_wd = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      chk("rnd_in_ready", 64'(in_ready), 64'((m_left == 0) && (!m_ov || out_ready)));
      chk("rnd_busy", 64'(busy), 64'(m_left > 0));
      chk("rnd_out_valid", 64'(out_valid), 64'(m_ov));
      if (m_ov) begin
        chk("rnd_res", aluResult_M, m_res);
        chk("rnd_pcb", PCBranch_M, m_pcb);
        chk("rnd_wd", writeData_M, m_wd);
        chk("rnd_zero", 64'(zero_M), 64'(m_res == 64'd0));
      end
      acc  = in_valid && (m_left == 0) && (!m_ov || out_ready);
      xfer = m_ov && out_ready;
      c_res = ref_alu(AluControl, readData1_E, ref_b(AluSrc, readData2_E, signImm_E, readData3_E));
      c_pcb = PC_E + (signImm_E << 2);
      @(posedge clk);
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_ov = 1'b1; m_res = p_res; m_pcb = p_pcb; m_wd = p_wd;
        end
      end else if (acc) begin
        if (AluControl == 4'b1000) begin
          m_left = 64; m_ov = 1'b0; p_res = c_res; p_pcb = c_pcb; p_wd = readData2_E;
        end else begin
          m_ov = 1'b1; m_res = c_res; m_pcb = c_pcb; m_wd = readData2_E;
        end
      end else if (xfer) begin
        m_ov = 1'b0;
      end
      #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      drive(2'($urandom_range(0, 3)), codes[$urandom_range(0, 7)],
            {$urandom, $urandom}, {$urandom, $urandom},
            ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom},
            ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom},
            {$urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
